// File: rtl/clk_meas.sv
// clk_meas: measures the period of a divided clock in fsys cycles, recovers the
// clk_gen divide factor and reports lock/error/timeout. Optional input synchronizer: CLK_MEAS_SYNC_EN.
module clk_meas #(
   parameter int unsigned SIZE     = 32,
   parameter int unsigned FACTOR_W = 5,
   parameter int unsigned LOCK_CNT = 2,
   parameter int unsigned TIMEOUT  = 262144
) (
   input  logic                clk_meas_fsys,
   input  logic                clk_meas_rst,
   input  logic                clk_meas_in,
   output logic [SIZE-1:0]     clk_meas_period,
   output logic [FACTOR_W-1:0] clk_meas_factor,
   output logic                clk_meas_valid,
   output logic                clk_meas_err,
   output logic                clk_meas_locked,
   output logic                clk_meas_timeout,
   output logic                clk_meas_update
);

   typedef enum logic [1:0] {IDLE, MEAS, LOCK, STALL} state_t;

   localparam logic [SIZE-1:0] TMO    = SIZE'(TIMEOUT);
   localparam logic [3:0]      LOCK_M = 4'(LOCK_CNT);

   state_t              state_q, state_d;
   logic                in_s, in_q, in_d;
   logic [SIZE-1:0]     cnt_q, cnt_d;
   logic [SIZE-1:0]     period_q, period_d;
   logic [FACTOR_W-1:0] factor_q, factor_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;
   logic                update_q, update_d;
   logic [3:0]          match_q, match_d, match_next;
   logic                rise, pow2, meas_ok, same_p, at_tmo, measure, stall_go;
   int unsigned         log2_v;

`ifdef CLK_MEAS_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk_meas_fsys or posedge clk_meas_rst) begin
      if (clk_meas_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= clk_meas_in;
         sync2_q <= sync1_q;
      end
   end

   assign in_s = sync2_q;
`else
   assign in_s = clk_meas_in;
`endif

   // On a rise cycle cnt_q holds the period since the previous rise.
   always_comb begin
      in_d   = in_s;
      rise   = in_s & ~in_q;
      at_tmo = (cnt_q == TMO);
      pow2   = (cnt_q != '0) && ((cnt_q & (cnt_q - 1'b1)) == '0);
      log2_v = 0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         if (cnt_q[i]) log2_v = i;
      end
      meas_ok = pow2 && (cnt_q >= SIZE'(2)) && (log2_v <= (32'd1 << FACTOR_W));
      same_p  = (cnt_q == period_q);
      if (!meas_ok)
         match_next = '0;
      else if (same_p)
         match_next = (match_q >= LOCK_M) ? LOCK_M : match_q + 4'd1;
      else
         match_next = 4'd1;
   end

   always_ff @(posedge clk_meas_fsys or posedge clk_meas_rst) begin
      if (clk_meas_rst) begin
         state_q  <= IDLE;
         in_q     <= 1'b0;
         cnt_q    <= '0;
         period_q <= '0;
         factor_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         update_q <= 1'b0;
         match_q  <= '0;
      end else begin
         state_q  <= state_d;
         in_q     <= in_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         factor_q <= factor_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         update_q <= update_d;
         match_q  <= match_d;
      end
   end

   // A rise always beats the timeout, so a period of exactly TIMEOUT is measured.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (rise) state_d = MEAS;
         MEAS: begin
            if (rise) begin
               if (meas_ok && (match_next == LOCK_M)) state_d = LOCK;
            end else if (at_tmo) begin
               state_d = STALL;
            end
         end
         LOCK: begin
            if (rise) begin
               if (!(meas_ok && same_p)) state_d = MEAS;
            end else if (at_tmo) begin
               state_d = STALL;
            end
         end
         STALL: if (rise) state_d = MEAS;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      measure  = rise && ((state_q == MEAS) || (state_q == LOCK));
      stall_go = !rise && at_tmo && ((state_q == MEAS) || (state_q == LOCK));
      cnt_d    = rise ? SIZE'(1) : (at_tmo ? cnt_q : cnt_q + 1'b1);
      period_d = period_q;
      factor_d = factor_q;
      valid_d  = valid_q;
      err_d    = err_q;
      match_d  = match_q;
      update_d = measure;
      if (measure) begin
         period_d = cnt_q;
         valid_d  = meas_ok;
         err_d    = !meas_ok;
         factor_d = meas_ok ? FACTOR_W'(log2_v - 1) : '0;
         match_d  = match_next;
      end else if (stall_go) begin
         valid_d = 1'b0;
         match_d = '0;
      end
      clk_meas_period  = period_q;
      clk_meas_factor  = factor_q;
      clk_meas_valid   = valid_q;
      clk_meas_err     = err_q;
      clk_meas_update  = update_q;
      clk_meas_locked  = (state_q == LOCK);
      clk_meas_timeout = (state_q == STALL);
   end

endmodule
